unidade_pc: RTL and testbench
=============================

Name: unidade_pc

Overview:
- Program-counter and next-PC stage directly upstream of the control unit.
- Holds the PC that addresses instruction memory, so it sources the opcode that unidade_controle decodes.
- Consumes the decoded jump, jumpreg, branch, halt, congela_in and congela_out signals and selects the next PC.
- Freezes the processor during IN/OUT until the user presses confirm. Stops permanently on HALT.

Parameters:
PC_W, 10, program-counter width in bits; instruction memory depth is 2^PC_W words.

Ports:
clock  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous active-low reset
jump  in  1  from control unit: absolute jump (J, JAL, NOP)
jumpreg  in  1  from control unit: jump to register value (JR)
branch  in  1  from control unit: conditional branch instruction
alu_zero  in  1  ALU branch condition; branch is taken when 1
halt  in  1  from control unit: HALT
congela_in  in  1  from control unit: IN waiting for user
congela_out  in  1  from control unit: OUT waiting for user
botao_confirma  in  1  user confirm button, active-high
alvo_jump  in  26  instruction[25:0] jump target
alvo_branch  in  16  absolute branch target (immediate field)
valor_reg  in  32  register-file read value for JR
pc  out  PC_W  current PC, to instruction memory
pc_mais1  out  PC_W  pc+1 mod 2^PC_W, for JAL link write
commit  out  1  instruction in this cycle executes; gates regwrite/memwrite downstream
aguardando  out  1  1 while in WAIT_IO (drives the "press confirm" LED)
parado  out  1  1 while in HALTED

Behaviour:
- Clock and reset: one clock (clock); reset_n asynchronous, active-low.
- Reset values: pc=0, state=RUN, aguardando=0, parado=0, button edge-detect history=0.
- commit is combinational:
  - 1 when state=RUN and not halt, congela_in or congela_out;
  - or when state=WAIT_IO and confirm edge=1;
  - otherwise 0.
- confirm edge: rising edge of the (optionally synchronised) button, i.e. current=1 and previous=0. A button held high never repeats.
- States: RUN, WAIT_IO, HALTED.
- RUN, priority order:
  - halt: go to HALTED, pc holds.
  - else congela_in or congela_out: go to WAIT_IO, pc holds. A confirm edge in this same cycle is ignored.
  - else jumpreg: pc <= valor_reg[PC_W-1:0].
  - else jump: pc <= alvo_jump[PC_W-1:0].
  - else branch and alu_zero: pc <= alvo_branch[PC_W-1:0].
  - else pc <= pc+1.
- WAIT_IO:
  - pc holds, aguardando=1.
  - On confirm edge: commit=1 for exactly that cycle, pc <= pc+1, return to RUN.
  - If the next instruction is also IN/OUT, a fresh press is required.
- HALTED: pc holds, parado=1, commit=0, all inputs ignored until reset_n.
- Width rules: targets wider than PC_W are truncated to the low PC_W bits. pc+1 wraps from 2^PC_W-1 to 0.
- Reset asserted mid-wait or while halted: immediate return to the reset values, independent of clock.
- Transition latency: WAIT_IO and HALTED are entered one clock after the decoding cycle. pc updates one clock after commit.

Optional Feature:
BOTAO_SYNC_EN
- Defined: botao_confirma passes through a 2-flop synchronizer, reset to 0, before edge detection. This adds 2 cycles from press to commit.
- Undefined: botao_confirma is taken as already synchronous and feeds edge detection directly; commit occurs in the first cycle the input is seen high.

Decomposition:
- Shared package pc_defs holds:
  - the state encoding: RUN=2'b00, WAIT_IO=2'b01, HALTED=2'b10;
  - the PC_W default;
  - the reset PC constant PC_RESET=0.
- One sub-module, detector_borda: optional 2-flop synchronizer plus rising-edge detector on the button, outputting a 1-cycle pulse.

Test Plan:
1. Reset released, all control inputs 0 for 5 cycles -> pc goes 0,1,2,3,4,5; commit=1 every cycle.
2. At pc=3: jump=1, alvo_jump=26'h0000040 -> next pc=64. Then branch=1, alu_zero=0 -> pc=65. Then branch=1, alu_zero=1, alvo_branch=16'h0007 -> pc=7.
3. At pc=7: jumpreg=1, valor_reg=32'h0000_0412, PC_W=10 -> pc=0x012 (truncated).
4. At pc=12: congela_in=1 with button already held high -> WAIT_IO, aguardando=1, commit=0, pc=12 held for 20 cycles. Release then press -> commit=1 for one cycle (2 cycles after press with BOTAO_SYNC_EN), pc=13.
5. At pc=20: halt=1 -> parado=1, pc=20 held for 50 cycles despite jump=1 and button presses. reset_n low -> pc=0 asynchronously.
6. At pc=1023: no control inputs -> pc wraps to 0. Separately, reset_n pulsed low during WAIT_IO -> state RUN, pc=0, aguardando=0.

Source files
------------

// File: rtl/unidade_pc_pkg.sv
// Shared definitions for the program-counter stage: state encoding, default
// PC width and reset PC.
package pc_defs;

  localparam int unsigned PC_W_DEF = 10;
  localparam int unsigned PC_RESET = 0;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IO = 2'b01,
    HALTED  = 2'b10
  } estado_t;

endpackage

// File: rtl/unidade_pc_detector_borda.sv
// Confirm-button rising-edge detector. Emits a one-cycle pulse per press; a
// held button never repeats. Optional macro BOTAO_SYNC_EN inserts a 2-flop
// synchronizer in front of the edge detector.
module detector_borda (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_botao,
  output logic o_pulso
);

  logic w_botao;
  logic r_anterior;

`ifdef BOTAO_SYNC_EN
  logic [1:0] r_sync;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_botao};
    end
  end

  assign w_botao = r_sync[1];
`else
  assign w_botao = i_botao;
`endif

  // History bit for edge detection.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_anterior <= 1'b0;
    end else begin
      r_anterior <= w_botao;
    end
  end

  assign o_pulso = w_botao & ~r_anterior;

endmodule

// File: rtl/unidade_pc.sv
// Program counter and next-PC selection. Freezes during IN/OUT until the
// confirm button is pressed, stops permanently on HALT until reset.
// Optional macro BOTAO_SYNC_EN: synchronize the confirm button (adds 2 cycles).
module unidade_pc
  import pc_defs::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            jump,
  input  logic            jumpreg,
  input  logic            branch,
  input  logic            alu_zero,
  input  logic            halt,
  input  logic            congela_in,
  input  logic            congela_out,
  input  logic            botao_confirma,
  input  logic [25:0]     alvo_jump,
  input  logic [15:0]     alvo_branch,
  input  logic [31:0]     valor_reg,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_mais1,
  output logic            commit,
  output logic            aguardando,
  output logic            parado
);

  estado_t         r_estado;
  logic [PC_W-1:0] r_pc;
  logic            r_aguardando;
  logic            r_parado;
  logic [PC_W-1:0] w_pc_mais1;
  logic [PC_W-1:0] w_pc_prox;
  logic            w_borda;
  logic            w_congela;
  logic            w_unused;

  detector_borda u_detector_borda (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_botao   (botao_confirma),
    .o_pulso   (w_borda)
  );

  assign w_congela  = congela_in | congela_out;
  assign w_pc_mais1 = r_pc + PC_W'(1);

  // Upper target bits are dropped on purpose; fold them here so they count as used.
  assign w_unused = ^{alvo_jump, alvo_branch, valor_reg};

  // Next PC while running normally; targets truncate to the low PC_W bits.
  always_comb begin
    w_pc_prox = w_pc_mais1;
    if (jumpreg) begin
      w_pc_prox = valor_reg[PC_W-1:0];
    end else if (jump) begin
      w_pc_prox = alvo_jump[PC_W-1:0];
    end else if (branch && alu_zero) begin
      w_pc_prox = alvo_branch[PC_W-1:0];
    end
  end

  // State machine with registered status outputs and the PC register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado     <= RUN;
      r_pc         <= PC_W'(PC_RESET);
      r_aguardando <= 1'b0;
      r_parado     <= 1'b0;
    end else begin
      unique case (r_estado)
        RUN: begin
          if (halt) begin
            r_estado <= HALTED;
            r_parado <= 1'b1;
          end else if (w_congela) begin
            // A confirm edge in this cycle is deliberately ignored.
            r_estado     <= WAIT_IO;
            r_aguardando <= 1'b1;
          end else begin
            r_pc <= w_pc_prox;
          end
        end
        WAIT_IO: begin
          if (w_borda) begin
            r_pc         <= w_pc_mais1;
            r_estado     <= RUN;
            r_aguardando <= 1'b0;
          end
        end
        HALTED: begin
          r_parado <= 1'b1;
        end
        default: begin
          r_estado     <= RUN;
          r_aguardando <= 1'b0;
          r_parado     <= 1'b0;
        end
      endcase
    end
  end

  assign commit = ((r_estado == RUN) && !halt && !w_congela) ||
                  ((r_estado == WAIT_IO) && w_borda);

  assign pc         = r_pc;
  assign pc_mais1   = w_pc_mais1;
  assign aguardando = r_aguardando;
  assign parado     = r_parado;

endmodule

// File: tb/tb_unidade_pc.sv
// Self-checking bench for unidade_pc: directed table, multi-cycle sequences and
// randomized stimulus against a behavioural model.
module tb_unidade_pc;

  localparam int PC_W  = 10;
  localparam int DEPTH = 1 << PC_W;
`ifdef BOTAO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic            clock = 1'b0;
  logic            reset_n;
  logic            jump, jumpreg, branch, alu_zero, halt;
  logic            congela_in, congela_out, botao_confirma;
  logic [25:0]     alvo_jump;
  logic [15:0]     alvo_branch;
  logic [31:0]     valor_reg;
  logic [PC_W-1:0] pc, pc_mais1;
  logic            commit, aguardando, parado;

  unidade_pc #(.PC_W(PC_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .jump           (jump),
    .jumpreg        (jumpreg),
    .branch         (branch),
    .alu_zero       (alu_zero),
    .halt           (halt),
    .congela_in     (congela_in),
    .congela_out    (congela_out),
    .botao_confirma (botao_confirma),
    .alvo_jump      (alvo_jump),
    .alvo_branch    (alvo_branch),
    .valor_reg      (valor_reg),
    .pc             (pc),
    .pc_mais1       (pc_mais1),
    .commit         (commit),
    .aguardando     (aguardando),
    .parado         (parado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model: PC value, waiting/halted flags, button sample history
  // (h0 = sampled at the last edge, h1 one edge earlier, h2 two edges earlier).
  int m_pc;
  bit m_wait, m_halt;
  bit h0, h1, h2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_wait = 0; m_halt = 0; h0 = 0; h1 = 0; h2 = 0;
  endtask

  function automatic bit press_edge();
`ifdef BOTAO_SYNC_EN
    return h1 && !h2;
`else
    return botao_confirma && !h0;
`endif
  endfunction

  task automatic clear_inputs();
    jump = 0; jumpreg = 0; branch = 0; alu_zero = 0; halt = 0;
    congela_in = 0; congela_out = 0;
    alvo_jump = '0; alvo_branch = '0; valor_reg = '0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(output bit c);
    bit e, exp_commit;
    @(negedge clock);
    e = press_edge();
    exp_commit = (!m_wait && !m_halt && !(halt || congela_in || congela_out)) ||
                 (m_wait && e);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_mais1", 32'(pc_mais1), 32'((m_pc + 1) % DEPTH));
    chk("commit", 32'(commit), 32'(exp_commit));
    chk("aguardando", 32'(aguardando), 32'(m_wait));
    chk("parado", 32'(parado), 32'(m_halt));
    c = commit;
    @(posedge clock);
    if (m_halt) begin
    end else if (m_wait) begin
      if (e) begin
        m_pc   = (m_pc + 1) % DEPTH;
        m_wait = 0;
      end
    end else if (halt) m_halt = 1;
    else if (congela_in || congela_out) m_wait = 1;
    else if (jumpreg) m_pc = int'(valor_reg) & (DEPTH - 1);
    else if (jump) m_pc = int'(alvo_jump) % DEPTH;
    else if (branch && alu_zero) m_pc = int'(alvo_branch) % DEPTH;
    else m_pc = (m_pc + 1) % DEPTH;
    h2 = h1; h1 = h0; h0 = botao_confirma;
    #1;
  endtask

  task automatic async_reset();
    #2;
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_aguardando", 32'(aguardando), 32'd0);
    chk("rst_parado", 32'(parado), 32'd0);
    reset_n = 1;
  endtask

  task automatic go_to(input int target);
    bit c;
    clear_inputs();
    jump = 1; alvo_jump = 26'(target);
    cycle(c);
    clear_inputs();
    chk("go_to_pc", 32'(pc), 32'(target));
  endtask

  typedef struct {
    bit          j, jr, br, z;
    logic [25:0] aj;
    logic [15:0] ab;
    logic [31:0] vr;
    int          exp_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    bit c;
    int cnt;

    tbl[0] = '{0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 1};
    tbl[1] = '{0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 2};
    tbl[2] = '{0, 0, 0, 0, 26'h0, 16'h0, 32'h0, 3};
    tbl[3] = '{1, 0, 0, 0, 26'h0000040, 16'h0, 32'h0, 64};
    tbl[4] = '{0, 0, 1, 0, 26'h0, 16'h0033, 32'h0, 65};
    tbl[5] = '{0, 0, 1, 1, 26'h0, 16'h0007, 32'h0, 7};
    tbl[6] = '{0, 1, 0, 0, 26'h0, 16'h0, 32'h0000_0412, 32'h012};
    tbl[7] = '{1, 1, 1, 1, 26'h3FF_0005, 16'h0009, 32'hFFFF_FC21, 32'h021};

    reset_n = 0;
    botao_confirma = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #3;
    chk("reset_pc", 32'(pc), 32'd0);
    chk("reset_aguardando", 32'(aguardando), 32'd0);
    chk("reset_parado", 32'(parado), 32'd0);
    reset_n = 1;

    // Sequential counting, jumps, branches, JR truncation and priority.
    for (int i = 0; i < 8; i++) begin
      jump = tbl[i].j; jumpreg = tbl[i].jr; branch = tbl[i].br; alu_zero = tbl[i].z;
      alvo_jump = tbl[i].aj; alvo_branch = tbl[i].ab; valor_reg = tbl[i].vr;
      cycle(c);
      chk($sformatf("tbl%0d_commit", i), 32'(c), 32'd1);
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
    end
    clear_inputs();

    // IN wait with button already held: no commit until a fresh press.
    go_to(12);
    botao_confirma = 1; congela_in = 1;
    cycle(c);
    chk("io_enter_commit", 32'(c), 32'd0);
    for (int i = 0; i < 20; i++) cycle(c);
    chk("io_hold_pc", 32'(pc), 32'd12);
    chk("io_hold_aguardando", 32'(aguardando), 32'd1);
    botao_confirma = 0;
    cycle(c);
    cycle(c);
    congela_in = 0; botao_confirma = 1;
    cnt = 0;
    cycle(c);
    while (!c && cnt < 6) begin
      cnt++;
      cycle(c);
    end
    chk("press_latency", 32'(cnt), 32'(LAT));
    chk("io_release_pc", 32'(pc), 32'd13);
    chk("io_release_aguardando", 32'(aguardando), 32'd0);
    botao_confirma = 0;
    cycle(c);

    // HALT ignores everything until reset.
    go_to(20);
    halt = 1;
    cycle(c);
    chk("halt_commit", 32'(c), 32'd0);
    halt = 0; jump = 1; alvo_jump = 26'd99;
    for (int i = 0; i < 50; i++) begin
      botao_confirma = 1'($urandom_range(0, 1));
      cycle(c);
    end
    chk("halted_pc", 32'(pc), 32'd20);
    chk("halted_parado", 32'(parado), 32'd1);
    clear_inputs(); botao_confirma = 0;
    async_reset();
    cycle(c);

    // Wrap-around, then reset during WAIT_IO.
    go_to(DEPTH - 1);
    cycle(c);
    chk("wrap_pc", 32'(pc), 32'd0);
    congela_out = 1;
    cycle(c);
    chk("wait_out_aguardando", 32'(aguardando), 32'd1);
    congela_out = 0;
    async_reset();
    cycle(c);
    chk("after_reset_commit", 32'(c), 32'd1);
    chk("after_reset_pc", 32'(pc), 32'd1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      jump        = ($urandom_range(0, 7) == 0);
      jumpreg     = ($urandom_range(0, 15) == 0);
      branch      = ($urandom_range(0, 3) == 0);
      alu_zero    = 1'($urandom_range(0, 1));
      halt        = ($urandom_range(0, 99) == 0);
      congela_in  = ($urandom_range(0, 11) == 0);
      congela_out = ($urandom_range(0, 11) == 0);
      botao_confirma = ($urandom_range(0, 2) == 0);
      alvo_jump   = 26'($urandom);
      alvo_branch = 16'($urandom);
      valor_reg   = $urandom;
      if (i % 97 == 96) async_reset();
      cycle(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
